// File: rtl/id_operand_sched.sv
// Decode-stage operand scheduler: forwarding select, load-use stall, registered ID/EX stage.
// Define ID_STALL_CNT_EN to add the saturating stall_total_o cycle counter.
module id_operand_sched #(
    parameter int DATA_W    = 32,
    parameter int RADDR_W   = 5,
    parameter int NFWD      = 2,
    parameter int MAX_STALL = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    id_valid_i,
    output logic                    id_ready_o,
    input  logic [RADDR_W-1:0]      id_rs_i,
    input  logic [RADDR_W-1:0]      id_rt_i,
    input  logic                    id_rd1_en_i,
    input  logic                    id_rd2_en_i,
    input  logic [DATA_W-1:0]       id_imm_i,
    input  logic [7:0]              id_aluop_i,
    input  logic [2:0]              id_alusel_i,
    input  logic [RADDR_W-1:0]      id_wd_i,
    input  logic                    id_wreg_i,
    output logic [RADDR_W-1:0]      rf_raddr1_o,
    output logic [RADDR_W-1:0]      rf_raddr2_o,
    output logic                    rf_re1_o,
    output logic                    rf_re2_o,
    input  logic [DATA_W-1:0]       rf_rdata1_i,
    input  logic [DATA_W-1:0]       rf_rdata2_i,
    input  logic [NFWD-1:0]         fwd_we_i,
    input  logic [NFWD-1:0]         fwd_rdy_i,
    input  logic [NFWD*RADDR_W-1:0] fwd_addr_i,
    input  logic [NFWD*DATA_W-1:0]  fwd_data_i,
    output logic                    ex_valid_o,
    input  logic                    ex_ready_i,
    output logic [DATA_W-1:0]       ex_op1_o,
    output logic [DATA_W-1:0]       ex_op2_o,
    output logic [7:0]              ex_aluop_o,
    output logic [2:0]              ex_alusel_o,
    output logic [RADDR_W-1:0]      ex_wd_o,
    output logic                    ex_wreg_o,
    output logic                    stall_o,
    output logic                    hazard_timeout_o
`ifdef ID_STALL_CNT_EN
    ,
    output logic [15:0]             stall_total_o
`endif
);

    localparam int CNT_W = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;

    typedef enum logic {RUN, DEP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_d;
    logic [DATA_W:0]    res1, res2;
    logic               adv;
    logic               accept;

    // Returns {hazard, value}; the first matching source from index 0 wins and hides older ones.
    function automatic logic [DATA_W:0] resolve(input logic [RADDR_W-1:0] addr,
                                                input logic               en,
                                                input logic [DATA_W-1:0]  rf_data);
        logic              found;
        logic              haz;
        logic [DATA_W-1:0] val;
        found = 1'b0;
        haz   = 1'b0;
        val   = rf_data;
        if (!en) begin
            val = id_imm_i;
        end else if (addr == '0) begin
            val = '0;
        end else begin
            for (int unsigned k = 0; k < NFWD; k++) begin
                if (!found && fwd_we_i[k] && (fwd_addr_i[k*RADDR_W +: RADDR_W] == addr)) begin
                    found = 1'b1;
                    haz   = !fwd_rdy_i[k];
                    val   = fwd_data_i[k*DATA_W +: DATA_W];
                end
            end
        end
        return {haz, val};
    endfunction

    always_comb begin
        res1       = resolve(id_rs_i, id_rd1_en_i, rf_rdata1_i);
        res2       = resolve(id_rt_i, id_rd2_en_i, rf_rdata2_i);
        stall_o    = id_valid_i & (res1[DATA_W] | res2[DATA_W]) & ~flush_i;
        adv        = ~ex_valid_o | ex_ready_i;
        id_ready_o = adv & ~stall_o & ~flush_i;
        accept     = adv & id_valid_i & ~stall_o;
    end

    assign rf_raddr1_o = id_rs_i;
    assign rf_raddr2_o = id_rt_i;
    assign rf_re1_o    = id_rd1_en_i & id_valid_i;
    assign rf_re2_o    = id_rd2_en_i & id_valid_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_o  <= 1'b0;
            ex_op1_o    <= '0;
            ex_op2_o    <= '0;
            ex_aluop_o  <= '0;
            ex_alusel_o <= '0;
            ex_wd_o     <= '0;
            ex_wreg_o   <= 1'b0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (accept) begin
            ex_valid_o  <= 1'b1;
            ex_op1_o    <= res1[DATA_W-1:0];
            ex_op2_o    <= res2[DATA_W-1:0];
            ex_aluop_o  <= id_aluop_i;
            ex_alusel_o <= id_alusel_i;
            ex_wd_o     <= id_wd_i;
            ex_wreg_o   <= id_wreg_i;
        end else if (adv) begin
            ex_valid_o <= 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = hazard_timeout_o;
        case (state_q)
            RUN: begin
                if (stall_o) begin
                    state_d = DEP;
                    cnt_d   = '0;
                end
            end
            DEP: begin
                if (!stall_o || flush_i) begin
                    state_d = RUN;
                end else begin
                    if (cnt_q != CNT_W'(MAX_STALL)) cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(MAX_STALL)) timeout_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= RUN;
            cnt_q            <= '0;
            hazard_timeout_o <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            hazard_timeout_o <= timeout_d;
        end
    end

`ifdef ID_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_total_o <= '0;
        end else if (stall_o && (stall_total_o != '1)) begin
            stall_total_o <= stall_total_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_operand_sched.sv
// Randomized scoreboard bench for id_operand_sched with a spec-level operand/stall reference model.
module tb_id_operand_sched;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NF = 2;
    localparam int MS = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush_i, id_valid_i, id_rd1_en_i, id_rd2_en_i, id_wreg_i, ex_ready_i;
    logic [AW-1:0] id_rs_i, id_rt_i, id_wd_i;
    logic [DW-1:0] id_imm_i, rf_rdata1_i, rf_rdata2_i;
    logic [7:0]    id_aluop_i;
    logic [2:0]    id_alusel_i;
    logic [NF-1:0] fwd_we_i, fwd_rdy_i;
    logic [AW-1:0] faddr [NF];
    logic [DW-1:0] fdata [NF];
    logic [NF*AW-1:0] fwd_addr_i;
    logic [NF*DW-1:0] fwd_data_i;

    logic          id_ready_o, rf_re1_o, rf_re2_o, ex_valid_o, ex_wreg_o, stall_o, hazard_timeout_o;
    logic [AW-1:0] rf_raddr1_o, rf_raddr2_o, ex_wd_o;
    logic [DW-1:0] ex_op1_o, ex_op2_o;
    logic [7:0]    ex_aluop_o;
    logic [2:0]    ex_alusel_o;
`ifdef ID_STALL_CNT_EN
    logic [15:0]   stall_total_o;
`endif

    always_comb begin
        fwd_addr_i = '0;
        fwd_data_i = '0;
        for (int k = 0; k < NF; k++) begin
            fwd_addr_i[k*AW +: AW] = faddr[k];
            fwd_data_i[k*DW +: DW] = fdata[k];
        end
    end

    id_operand_sched #(
        .DATA_W(DW), .RADDR_W(AW), .NFWD(NF), .MAX_STALL(MS)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_rd1_en_i(id_rd1_en_i), .id_rd2_en_i(id_rd2_en_i),
        .id_imm_i(id_imm_i), .id_aluop_i(id_aluop_i), .id_alusel_i(id_alusel_i),
        .id_wd_i(id_wd_i), .id_wreg_i(id_wreg_i),
        .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
        .rf_re1_o(rf_re1_o), .rf_re2_o(rf_re2_o),
        .rf_rdata1_i(rf_rdata1_i), .rf_rdata2_i(rf_rdata2_i),
        .fwd_we_i(fwd_we_i), .fwd_rdy_i(fwd_rdy_i),
        .fwd_addr_i(fwd_addr_i), .fwd_data_i(fwd_data_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o),
        .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o),
        .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o),
        .stall_o(stall_o), .hazard_timeout_o(hazard_timeout_o)
`ifdef ID_STALL_CNT_EN
        , .stall_total_o(stall_total_o)
`endif
    );

    typedef struct {
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [16:0]   ctrl;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model state: expected ex_valid, sticky timeout, length of current stall run, total stall cycles.
    logic m_valid = 1'b0;
    logic m_to    = 1'b0;
    int   m_run   = 0;
    int   m_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Oldest source first so that a younger match simply overwrites it.
    function automatic void ref_op(input logic [AW-1:0] a, input logic en, input logic [DW-1:0] rf,
                                   output logic [DW-1:0] v, output logic h);
        h = 1'b0;
        v = rf;
        if (!en) v = id_imm_i;
        else if (a == 0) v = '0;
        else begin
            for (int k = NF - 1; k >= 0; k--) begin
                if (fwd_we_i[k] && faddr[k] == a) begin
                    h = !fwd_rdy_i[k];
                    v = fdata[k];
                end
            end
        end
    endfunction

    // Called at a falling edge with inputs applied; returns at the next falling edge.
    task automatic tick();
        logic [DW-1:0] v1, v2;
        logic h1, h2, st, adv, acc;
        #2;
        ref_op(id_rs_i, id_rd1_en_i, rf_rdata1_i, v1, h1);
        ref_op(id_rt_i, id_rd2_en_i, rf_rdata2_i, v2, h2);
        st  = id_valid_i && (h1 || h2) && !flush_i;
        adv = !m_valid || ex_ready_i;
        acc = id_valid_i && adv && !st && !flush_i;
        chk("stall_o", 64'(stall_o), 64'(st));
        chk("id_ready_o", 64'(id_ready_o), 64'(adv && !st && !flush_i));
        chk("ex_valid_o", 64'(ex_valid_o), 64'(m_valid));
        chk("hazard_timeout_o", 64'(hazard_timeout_o), 64'(m_to));
        chk("rf_re1_o", 64'(rf_re1_o), 64'(id_rd1_en_i && id_valid_i));
        chk("rf_raddr2_o", 64'(rf_raddr2_o), 64'(id_rt_i));
`ifdef ID_STALL_CNT_EN
        chk("stall_total_o", 64'(stall_total_o), 64'(m_total));
`endif
        if (rst) begin
            sb.delete();
            m_valid = 1'b0;
            m_to    = 1'b0;
            m_run   = 0;
            m_total = 0;
        end else begin
            if (acc) sb.push_back('{v1, v2, {id_aluop_i, id_alusel_i, id_wd_i, id_wreg_i}});
            if (flush_i) m_valid = 1'b0;
            else if (adv) m_valid = acc;
            if (st) begin
                m_run++;
                if (m_run > MS) m_to = 1'b1;
                if (m_total < 65535) m_total++;
            end else begin
                m_run = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; flush_i = 1'b0; id_valid_i = 1'b0; ex_ready_i = 1'b1;
        id_rd1_en_i = 1'b0; id_rd2_en_i = 1'b0; id_wreg_i = 1'b0;
        id_rs_i = '0; id_rt_i = '0; id_wd_i = '0; id_imm_i = '0;
        rf_rdata1_i = '0; rf_rdata2_i = '0; id_aluop_i = '0; id_alusel_i = '0;
        fwd_we_i = '0; fwd_rdy_i = '1;
        for (int k = 0; k < NF; k++) begin
            faddr[k] = '0;
            fdata[k] = '0;
        end
    endtask

    // Monitor: pops an entry whenever the ID/EX register is consumed or discarded.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && ex_valid_o && (ex_ready_i || flush_i)) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: ex_valid_o=1 with no expected entry at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    if (ex_ready_i) begin
                        chk("ex_op1_o", 64'(ex_op1_o), 64'(e.op1));
                        chk("ex_op2_o", 64'(ex_op2_o), 64'(e.op2));
                        chk("ex_ctrl", 64'({ex_aluop_o, ex_alusel_o, ex_wd_o, ex_wreg_o}), 64'(e.ctrl));
                    end
                end
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);
        tick();
        tick();
        chk("t1_valid", 64'(ex_valid_o), 64'd0);
        chk("t1_op1", 64'(ex_op1_o), 64'd0);
        chk("t1_timeout", 64'(hazard_timeout_o), 64'd0);
        rst = 1'b0;

        id_valid_i = 1'b1; id_rd1_en_i = 1'b1; id_rs_i = 5'd5; rf_rdata1_i = 32'h33;
        id_aluop_i = 8'h21; id_alusel_i = 3'd4; id_wd_i = 5'd9; id_wreg_i = 1'b1;
        fwd_we_i = 2'b11; fwd_rdy_i = 2'b11;
        faddr[0] = 5'd5; fdata[0] = 32'h11; faddr[1] = 5'd5; fdata[1] = 32'h22;
        tick();
        chk("t2_op1", 64'(ex_op1_o), 64'h11);
        chk("t2_valid", 64'(ex_valid_o), 64'd1);

        id_rs_i = 5'd0; fwd_we_i = 2'b01; faddr[0] = 5'd0; fdata[0] = 32'hFFFF_FFFF;
        tick();
        chk("t3_r0", 64'(ex_op1_o), 64'd0);
        id_rd1_en_i = 1'b0; id_imm_i = 32'h1234;
        tick();
        chk("t3_imm", 64'(ex_op1_o), 64'h1234);

        id_rd2_en_i = 1'b1; id_rt_i = 5'd7; faddr[0] = 5'd7; fdata[0] = 32'hAB; fwd_rdy_i = 2'b10;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t4_stall", 64'(stall_o), 64'd1);
            chk("t4_ready", 64'(id_ready_o), 64'd0);
            tick();
            chk("t4_bubble", 64'(ex_valid_o), 64'd0);
        end
        fwd_rdy_i = 2'b11;
        tick();
        chk("t4_op2", 64'(ex_op2_o), 64'hAB);

        ex_ready_i = 1'b0; id_rd1_en_i = 1'b1; id_rd2_en_i = 1'b0; id_rs_i = 5'd9;
        fwd_we_i = '0; rf_rdata1_i = 32'hC0FFEE;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_ready", 64'(id_ready_o), 64'd0);
            tick();
            chk("t5_hold", 64'(ex_op2_o), 64'hAB);
        end
        ex_ready_i = 1'b1;
        tick();
        chk("t5_new", 64'(ex_op1_o), 64'hC0FFEE);

        for (int n = 0; n < 1500; n++) begin
            rst         = ($urandom_range(0, 299) == 0);
            flush_i     = ($urandom_range(0, 19) == 0);
            id_valid_i  = ($urandom_range(0, 4) != 0);
            ex_ready_i  = ($urandom_range(0, 9) < 7);
            id_rd1_en_i = ($urandom_range(0, 3) != 0);
            id_rd2_en_i = ($urandom_range(0, 3) != 0);
            id_rs_i     = AW'($urandom_range(0, 3));
            id_rt_i     = AW'($urandom_range(0, 3));
            id_wd_i     = AW'($urandom);
            id_wreg_i   = 1'($urandom);
            id_imm_i    = $urandom;
            id_aluop_i  = 8'($urandom);
            id_alusel_i = 3'($urandom);
            rf_rdata1_i = $urandom;
            rf_rdata2_i = $urandom;
            for (int k = 0; k < NF; k++) begin
                fwd_we_i[k]  = 1'($urandom);
                fwd_rdy_i[k] = ($urandom_range(0, 3) != 0);
                faddr[k]     = AW'($urandom_range(0, 3));
                fdata[k]     = $urandom;
            end
            tick();
        end

        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        id_valid_i = 1'b1; id_rd1_en_i = 1'b1; id_rs_i = 5'd3;
        fwd_we_i = 2'b01; fwd_rdy_i = 2'b00; faddr[0] = 5'd3;
        for (int i = 0; i < MS; i++) tick();
        chk("t6_before", 64'(hazard_timeout_o), 64'd0);
        tick();
        chk("t6_timeout", 64'(hazard_timeout_o), 64'd1);
        flush_i = 1'b1;
        tick();
        chk("t6_flush_valid", 64'(ex_valid_o), 64'd0);
        idle();
        id_valid_i = 1'b1; id_rd1_en_i = 1'b1; id_rs_i = 5'd3; rf_rdata1_i = 32'h5A5A;
        tick();
        tick();
        chk("t6_after_op1", 64'(ex_op1_o), 64'h5A5A);
        chk("t6_sticky", 64'(hazard_timeout_o), 64'd1);
`ifdef ID_STALL_CNT_EN
        chk("t6_total", 64'(stall_total_o), 64'd16);
`endif
        idle();
        tick();
        tick();
        chk("sb_drain", 64'(sb.size()), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_timeout", 64'(hazard_timeout_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
